fb_arbiter: RTL

Two-port arbiter and sequencer for the single-port 8-bit frame-buffer RAM (76800 × 8, 320×240). Shares the RAM between a pixel writer (camera/packet ingest) and a pixel reader (display scan-out). Each port is a raster stream with an internal auto-incrementing address. Reads have priority, bounded by a starvation guard for the writer. The arbiter drives the RAM's addr/data_in/write/ENABLE pins and returns read data with fixed latency.

---
 rtl/fb_pkg.sv | 21 ++
 rtl/fb_addr_counter.sv | 64 ++++++
 rtl/fb_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared constants and encodings for the frame-buffer arbiter.
// Port state and grant enums are used by the top level and the address counter.
package fb_pkg;

   localparam int DATA_WIDTH    = 8;
   localparam int ADDR_WIDTH    = 20;
   localparam int DEPTH         = 76800;
   localparam int RD_STREAK_MAX = 3;

   typedef enum logic {
      PORT_IDLE   = 1'b0,
      PORT_ACTIVE = 1'b1
   } port_state_e;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_RD   = 2'd1,
      GNT_WR   = 2'd2
   } grant_e;

endpackage

// File: rtl/fb_addr_counter.sv
// Per-port raster address sequencer: start, increment on grant, end-of-frame detect.
// The port drops back to idle after the last address and pulses frame_done once.
module fb_addr_counter #(
   parameter int ADDR_WIDTH = fb_pkg::ADDR_WIDTH,
   parameter int DEPTH      = fb_pkg::DEPTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  grant,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  active,
   output logic                  frame_done
);
   import fb_pkg::*;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   port_state_e           state_r;
   port_state_e           state_n;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [ADDR_WIDTH-1:0] addr_n;
   logic                  done_r;
   logic                  done_n;

   // State, address and done-pulse registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= PORT_IDLE;
         addr_r  <= '0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_n;
         addr_r  <= addr_n;
         done_r  <= done_n;
      end
   end

   // Next state: a start always wins and aborts any frame in progress without a done pulse
   always_comb begin
      state_n = state_r;
      addr_n  = addr_r;
      done_n  = 1'b0;
      if (start) begin
         state_n = PORT_ACTIVE;
         addr_n  = '0;
      end else if (grant) begin
         if (addr_r == LAST_ADDR) begin
            state_n = PORT_IDLE;
            addr_n  = '0;
            done_n  = 1'b1;
         end else begin
            addr_n = addr_r + ADDR_WIDTH'(1);
         end
      end else begin
         state_n = state_r;
      end
   end

   assign addr       = addr_r;
   assign active     = (state_r == PORT_ACTIVE);
   assign frame_done = done_r;

endmodule

// File: rtl/fb_arbiter.sv
// Two-port arbiter for the single-port frame-buffer RAM: reader priority with a
// bounded read streak so a pending writer always gets a slot.
module fb_arbiter #(
   parameter int DATA_WIDTH    = fb_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH    = fb_pkg::ADDR_WIDTH,
   parameter int DEPTH         = fb_pkg::DEPTH,
   parameter int RD_STREAK_MAX = fb_pkg::RD_STREAK_MAX
) (
   input  logic                  CLOCK_50,
   input  logic                  RESET,
   input  logic                  wr_start,
   input  logic                  wr_valid,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_ready,
   output logic                  wr_frame_done,
   input  logic                  rd_start,
   input  logic                  rd_req,
   output logic                  rd_ready,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_frame_done,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   output logic                  ram_write,
   output logic                  ram_enable,
   input  logic [DATA_WIDTH-1:0] ram_out_data
);
   import fb_pkg::*;

   localparam int STREAK_WIDTH = (RD_STREAK_MAX < 1) ? 1 : $clog2(RD_STREAK_MAX + 1);
   localparam logic [STREAK_WIDTH-1:0] STREAK_SAT = STREAK_WIDTH'(RD_STREAK_MAX);

   logic [ADDR_WIDTH-1:0]   wr_addr_s;
   logic [ADDR_WIDTH-1:0]   rd_addr_s;
   logic                    wr_active_s;
   logic                    rd_active_s;
   logic                    wr_pend_s;
   logic                    rd_pend_s;
   grant_e                  grant_s;
   logic [STREAK_WIDTH-1:0] streak_r;
   logic [1:0]              rd_pipe_r;

   assign wr_pend_s = wr_active_s & wr_valid & ~wr_start;
   assign rd_pend_s = rd_active_s & rd_req & ~rd_start;

   fb_addr_counter #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_wr_cnt (
      .clk        (CLOCK_50),
      .reset      (RESET),
      .start      (wr_start),
      .grant      (grant_s == GNT_WR),
      .addr       (wr_addr_s),
      .active     (wr_active_s),
      .frame_done (wr_frame_done)
   );

   fb_addr_counter #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_rd_cnt (
      .clk        (CLOCK_50),
      .reset      (RESET),
      .start      (rd_start),
      .grant      (grant_s == GNT_RD),
      .addr       (rd_addr_s),
      .active     (rd_active_s),
      .frame_done (rd_frame_done)
   );

   // Single grant per cycle; a saturated streak hands the slot to the writer
   always_comb begin
      grant_s = GNT_NONE;
      if (rd_pend_s && wr_pend_s) begin
         grant_s = (streak_r == STREAK_SAT) ? GNT_WR : GNT_RD;
      end else if (rd_pend_s) begin
         grant_s = GNT_RD;
      end else if (wr_pend_s) begin
         grant_s = GNT_WR;
      end else begin
         grant_s = GNT_NONE;
      end
   end

   assign wr_ready = (grant_s == GNT_WR);
   assign rd_ready = (grant_s == GNT_RD);

   // Read streak counter, only meaningful while the writer is waiting
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         streak_r <= '0;
      end else if (grant_s == GNT_WR || !wr_pend_s) begin
         streak_r <= '0;
      end else if (grant_s == GNT_RD && streak_r != STREAK_SAT) begin
         streak_r <= streak_r + STREAK_WIDTH'(1);
      end else begin
         streak_r <= streak_r;
      end
   end

   // RAM command registers; address and data hold when idle
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         ram_addr    <= '0;
         ram_data_in <= '0;
         ram_write   <= 1'b0;
         ram_enable  <= 1'b0;
      end else begin
         case (grant_s)
            GNT_WR: begin
               ram_addr    <= wr_addr_s;
               ram_data_in <= wr_data;
               ram_write   <= 1'b1;
               ram_enable  <= 1'b1;
            end
            GNT_RD: begin
               ram_addr   <= rd_addr_s;
               ram_write  <= 1'b0;
               ram_enable <= 1'b1;
            end
            default: begin
               ram_write  <= 1'b0;
               ram_enable <= 1'b0;
            end
         endcase
      end
   end

   // Read-valid pipeline: command register stage, then RAM output register stage
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         rd_pipe_r <= 2'b00;
      end else begin
         rd_pipe_r <= {rd_pipe_r[0], (grant_s == GNT_RD)};
      end
   end

   assign rd_valid = rd_pipe_r[1];
   assign rd_data  = rd_pipe_r[1] ? ram_out_data : '0;

endmodule
